// File: rtl/tw_serial_pkg.sv
// tw_serial_pkg: shared FSM state type and command-byte layout constants
package tw_serial_pkg;
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;
  localparam int CMD_RD_BIT = 0;
  localparam int CMD_VALID_BIT = 7;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/tw_serial_target_if.sv
// tw_serial_target_if: local fabric port into the register file
interface tw_serial_target_if #(parameter int ADDR_W = 5);
  import tw_serial_pkg::*;
  logic [ADDR_W-1:0] loc_addr;
  logic loc_we;
  logic [BYTE_W-1:0] loc_wdata;
  logic [BYTE_W-1:0] loc_rdata;
  logic loc_ready;
  modport master(output loc_addr, loc_we, loc_wdata, input loc_rdata, loc_ready);
  modport slave(input loc_addr, loc_we, loc_wdata, output loc_rdata, loc_ready);
endinterface

// File: rtl/tw_sync_edge.sv
// tw_sync_edge: N-flop synchroniser with single-cycle rise/fall pulses
module tw_sync_edge #(parameter int STAGES = 2) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] ff;
  logic prev;
  // shift the pin through the chain and remember the last synchronised value
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ff <= '0;
      prev <= 1'b0;
    end else begin
      ff <= STAGES'({ff, d});
      prev <= ff[STAGES-1];
    end
  assign q = ff[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/tw_serial_target.sv
// tw_serial_target: 3-wire serial responder over a byte register file shared with a local port
module tw_serial_target import tw_serial_pkg::*; #(
  parameter int ADDR_W = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ser_ce,
  input  logic ser_sclk,
  inout  wire  ser_io,
  tw_serial_target_if.slave loc,
  output logic busy,
  output logic cmd_err
);
  localparam int DEPTH = 2**ADDR_W;
  state_t state, state_nx;
  logic ce_s, sclk_rise, sclk_fall, io_s;
  logic [2:0] cnt;
  logic [BYTE_W-1:0] sh;
  logic [ADDR_W-1:0] addr;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic oe, obit, io_oe, last, cmd_done, commit;
  tw_sync_edge #(.STAGES(SYNC_STAGES)) u_ce (.clk(clk), .reset_n(reset_n), .d(ser_ce), .q(ce_s), .rise(), .fall());
  tw_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .reset_n(reset_n), .d(ser_sclk), .q(), .rise(sclk_rise), .fall(sclk_fall));
  tw_sync_edge #(.STAGES(SYNC_STAGES)) u_io (.clk(clk), .reset_n(reset_n), .d(ser_io), .q(io_s), .rise(), .fall());
  assign ser_io = io_oe ? obit : 1'bz;
  assign loc.loc_rdata = mem[loc.loc_addr];
  assign last = cnt == 3'(BYTE_W-1);
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // next state: CE low aborts from anywhere, the command byte picks the data phase
  always_comb begin
    state_nx = state;
    if (!ce_s) state_nx = IDLE;
    else if (state == IDLE) state_nx = CMD;
    else if (cmd_done) state_nx = !io_s ? IGNORE : sh[CMD_RD_BIT] ? RDATA : WDATA;
  end
  // outputs: a serial commit owns the memory write port for that one cycle
  always_comb begin
    cmd_done = state == CMD && ce_s && sclk_rise && cnt == 3'(CMD_VALID_BIT);
    commit = state == WDATA && ce_s && sclk_rise && last;
    cmd_err = cmd_done && !io_s;
    busy = state != IDLE;
    io_oe = oe && ce_s && state == RDATA;
    loc.loc_ready = !commit;
  end
  // datapath: bit shifting, burst address, read snapshot and register file
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      sh <= '0;
      addr <= '0;
      oe <= 1'b0;
      obit <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (loc.loc_we && !commit) mem[loc.loc_addr] <= loc.loc_wdata;
      if (!ce_s || state == IDLE || state == IGNORE) begin
        cnt <= '0;
        oe <= 1'b0;
      end else if ((state == CMD || state == WDATA) && sclk_rise) begin
        sh[cnt] <= io_s;
        cnt <= cnt + 3'd1;
        if (cmd_done) addr <= sh[ADDR_W:1];
        if (commit) begin
          mem[addr] <= {io_s, sh[BYTE_W-2:0]};
          addr <= addr + ADDR_W'(1);
        end
      end else if (state == RDATA && sclk_fall) begin
        oe <= 1'b1;
        obit <= cnt == '0 ? mem[addr][0] : sh[cnt];
        if (cnt == '0) sh <= mem[addr];
        cnt <= cnt + 3'd1;
        if (last) addr <= addr + ADDR_W'(1);
      end
    end
endmodule

// File: tb/tb_tw_serial_target.sv
// tb_tw_serial_target: randomized scoreboard bench against a byte-array model
module tb_tw_serial_target;
  localparam int ADDR_W = 5;
  localparam int DEPTH = 32;
  localparam int H = 6;
  logic clk = 0, reset_n = 0, ser_ce = 0, ser_sclk = 0, tb_oe = 0, tb_io = 0;
  wire ser_io;
  logic busy, cmd_err;
  int checks = 0, errors = 0, err_pulses = 0, rdy_low = 0, rcnt = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] dbuf [4];
  logic [7:0] exp_q [$];
  logic [7:0] rbuf;
  bit rd_phase = 0;

  assign ser_io = tb_oe ? tb_io : 1'bz;
  tw_serial_target_if #(.ADDR_W(ADDR_W)) loc();
  tw_serial_target #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .ser_ce(ser_ce), .ser_sclk(ser_sclk), .ser_io(ser_io),
    .loc(loc.slave), .busy(busy), .cmd_err(cmd_err));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
    if (!loc.loc_ready) rdy_low++;
  end

  // monitor: reassemble LSB-first read bytes on SCLK rise and score them
  always @(posedge ser_sclk) begin
    if (!rd_phase) chk("io_z_nonread", int'(dut.io_oe), 0);
    else begin
      chk("rd_oe", int'(dut.io_oe), 1);
      rbuf[rcnt] = ser_io;
      rcnt++;
      if (rcnt == 8) begin
        rcnt = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected actual=%0h expected=none", rbuf);
        end else chk("rd_byte", rbuf, exp_q.pop_front());
      end
    end
  end

  task automatic sbit(input logic b);
    @(negedge clk);
    ser_sclk = 0;
    tb_io = b;
    repeat (H) @(negedge clk);
    ser_sclk = 1;
    repeat (H) @(negedge clk);
  endtask

  task automatic sbyte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sbit(b[i]);
  endtask

  task automatic ce_on();
    @(negedge clk);
    ser_ce = 1;
    ser_sclk = 0;
    tb_oe = 1;
    repeat (H) @(negedge clk);
  endtask

  task automatic ce_off();
    @(negedge clk);
    ser_ce = 0;
    repeat (4) @(negedge clk);
    chk("io_released", int'(dut.io_oe), 0);
    chk("busy_idle", busy, 0);
    rd_phase = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wr_txn(input int a, input int n);
    ce_on();
    sbyte(8'h80 | 8'(a << 1));
    for (int i = 0; i < n; i++) begin
      sbyte(dbuf[i]);
      model[(a + i) % DEPTH] = dbuf[i];
    end
    ce_off();
  endtask

  task automatic rd_txn(input int a, input int n);
    ce_on();
    sbyte(8'h81 | 8'(a << 1));
    tb_oe = 0;
    rd_phase = 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model[(a + i) % DEPTH]);
      for (int k = 0; k < 8; k++) sbit(1'b0);
    end
    ce_off();
    chk("rd_drained", exp_q.size(), 0);
  endtask

  task automatic lwr(input int a, input logic [7:0] d);
    @(negedge clk);
    loc.loc_addr = ADDR_W'(a);
    loc.loc_wdata = d;
    loc.loc_we = 1;
    @(negedge clk);
    loc.loc_we = 0;
    model[a] = d;
  endtask

  task automatic lchk(input string name, input int a);
    @(negedge clk);
    loc.loc_addr = ADDR_W'(a);
    #1 chk(name, loc.loc_rdata, model[a]);
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < DEPTH; i++) lchk(name, i);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int e, rl, kind, a, n;
    logic [7:0] d;
    loc.loc_addr = '0;
    loc.loc_we = 0;
    loc.loc_wdata = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_ready", loc.loc_ready, 1);
    chk("rst_io_oe", int'(dut.io_oe), 0);
    reset_n = 1;
    check_all("rst_mem");
    // write 0xA5 to address 0
    rl = rdy_low;
    dbuf[0] = 8'hA5;
    wr_txn(0, 1);
    chk("write_commit_cycles", rdy_low - rl, 1);
    lchk("write_a5", 0);
    // read back a locally written byte
    lwr(3, 8'h3C);
    rd_txn(3, 1);
    // burst wraps from the top address to zero
    dbuf[0] = 8'h11;
    dbuf[1] = 8'h22;
    wr_txn(31, 2);
    lchk("wrap_31", 31);
    lchk("wrap_0", 0);
    // abort after half a data byte
    lwr(1, 8'h5A);
    ce_on();
    sbyte(8'h82);
    sbit(1); sbit(0); sbit(1); sbit(0);
    ce_off();
    lchk("abort_keep", 1);
    dbuf[0] = 8'h77;
    wr_txn(4, 1);
    lchk("after_abort", 4);
    // invalid command is flagged once and the rest is ignored
    e = err_pulses;
    rl = rdy_low;
    ce_on();
    sbyte(8'h05);
    repeat (4) @(negedge clk);
    chk("ignore_busy", busy, 1);
    sbyte(8'h80);
    sbyte(8'hFF);
    ce_off();
    chk("cmd_err_pulses", err_pulses - e, 1);
    chk("ignore_no_commit", rdy_low - rl, 0);
    check_all("ignore_mem");
    // local write held across a serial commit to the same address
    d = 8'h96;
    ce_on();
    sbyte(8'h84);
    for (int i = 0; i < 7; i++) sbit(d[i]);
    rl = rdy_low;
    @(negedge clk);
    loc.loc_addr = 5'd2;
    loc.loc_wdata = 8'hC3;
    loc.loc_we = 1;
    sbit(d[7]);
    repeat (2) @(negedge clk);
    loc.loc_we = 0;
    chk("collision_ready_low", rdy_low - rl, 1);
    ce_off();
    model[2] = 8'hC3;
    lchk("collision_mem", 2);
    // randomized mix of bursts and local writes
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 3);
      if (kind == 0) begin
        for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
        wr_txn(a, n);
      end else if (kind == 1) rd_txn(a, n);
      else lwr(a, 8'($urandom));
    end
    check_all("random_final");
    // reset in the middle of a transaction clears everything
    lwr(5, 8'hEE);
    ce_on();
    sbyte(8'h8A);
    sbit(1); sbit(1); sbit(0);
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_io_oe", int'(dut.io_oe), 0);
    ser_ce = 0;
    ser_sclk = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    check_all("midrst_mem");
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
